// File: rtl/audio_mac_sched_pkg.sv
// Shared constants, term payload and output saturation for the audio MAC scheduler.
package audio_mac_pkg;

  localparam int unsigned N_REQ    = 4;
  localparam int unsigned A_W      = 16;
  localparam int unsigned B_W      = 18;
  localparam int unsigned ACC_W    = 40;
  localparam int unsigned FRAC     = 15;
  localparam int unsigned REQ_ID_W = $clog2(N_REQ);
  localparam int unsigned P_W      = A_W + B_W;
  localparam int unsigned OUT_W    = 16;

  localparam logic [OUT_W-1:0] OUT_MAX = 16'h7FFF;
  localparam logic [OUT_W-1:0] OUT_MIN = 16'h8000;

  typedef struct packed {
    logic [A_W-1:0]      a;
    logic [B_W-1:0]      b;
    logic [REQ_ID_W-1:0] id;
    logic                first;
    logic                last;
  } mac_term_t;

  // Clamp a shifted accumulator value into the signed 16-bit output range.
  function automatic logic [OUT_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = $signed(ACC_W'(OUT_MAX));
    lo = ~hi;
    if (v > hi) begin
      return OUT_MAX;
    end else if (v < lo) begin
      return OUT_MIN;
    end else begin
      return v[OUT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/audio_mac_sched_if.sv
// Requester/result bus of the audio MAC scheduler.
interface audio_mac_sched_if;
  import audio_mac_pkg::*;

  logic                  en;
  logic [N_REQ-1:0]      req;
  logic [N_REQ*A_W-1:0]  a_in;
  logic [N_REQ*B_W-1:0]  b_in;
  logic [N_REQ-1:0]      first;
  logic [N_REQ-1:0]      last;
  logic [N_REQ-1:0]      gnt;
  logic                  done_valid;
  logic [REQ_ID_W-1:0]   done_id;
  logic [OUT_W-1:0]      done_data;

  modport master (
    output en, req, a_in, b_in, first, last,
    input  gnt, done_valid, done_id, done_data
  );

  modport slave (
    input  en, req, a_in, b_in, first, last,
    output gnt, done_valid, done_id, done_data
  );

endinterface

// File: rtl/audio_mac_sched_arb.sv
// Round-robin arbiter: one-hot combinational grant, pointer follows the last transfer.
module audio_rr_arb
  import audio_mac_pkg::*;
(
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                en_i,
  input  logic [N_REQ-1:0]    req_i,
  output logic [N_REQ-1:0]    gnt_o,
  output logic [REQ_ID_W-1:0] gnt_id_o,
  output logic                xfer_o
);

  logic [REQ_ID_W-1:0] ptr_q;
  logic [REQ_ID_W-1:0] ptr_d;
  logic [REQ_ID_W-1:0] idx_c;
  logic                found_c;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= REQ_ID_W'(N_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Search starts one past the last winner and wraps modulo N_REQ.
  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    idx_c    = '0;
    found_c  = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx_c = REQ_ID_W'((32'(ptr_q) + k) % N_REQ);
      if (!found_c && req_i[idx_c]) begin
        found_c  = 1'b1;
        gnt_id_o = idx_c;
      end
    end
    if (reset_i || !en_i) begin
      found_c = 1'b0;
    end
    if (found_c) begin
      gnt_o[gnt_id_o] = 1'b1;
    end
  end

  assign xfer_o = found_c;
  assign ptr_d  = found_c ? gnt_id_o : ptr_q;

endmodule

// File: rtl/audio_mac_sched.sv
// Time-shared signed MAC: RR issue, 3-stage multiply/accumulate pipeline, saturated tagged results.
module audio_mac_sched
  import audio_mac_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  audio_mac_sched_if.slave bus
);

  logic [N_REQ-1:0]        gnt_c;
  logic [REQ_ID_W-1:0]     gnt_id_c;
  logic                    xfer_c;
  logic [A_W-1:0]          a_arr_c [N_REQ];
  logic [B_W-1:0]          b_arr_c [N_REQ];
  mac_term_t               term_c;

  mac_term_t               s1_q, s1_d;
  logic                    v1_q, v1_d;
  logic signed [P_W-1:0]   p2_q, p2_d;
  logic [REQ_ID_W-1:0]     id2_q, id2_d;
  logic                    first2_q, first2_d;
  logic                    last2_q, last2_d;
  logic                    v2_q, v2_d;
  logic signed [ACC_W-1:0] acc_q [N_REQ];
  logic signed [ACC_W-1:0] acc_sum_c;
  logic                    done_valid_q, done_valid_d;
  logic [REQ_ID_W-1:0]     done_id_q, done_id_d;
  logic [OUT_W-1:0]        done_data_q, done_data_d;

  audio_rr_arb u_arb (
    .clk_i    (clk),
    .reset_i  (reset),
    .en_i     (bus.en),
    .req_i    (bus.req),
    .gnt_o    (gnt_c),
    .gnt_id_o (gnt_id_c),
    .xfer_o   (xfer_c)
  );

  assign bus.gnt = gnt_c;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign a_arr_c[i] = bus.a_in[i*A_W +: A_W];
    assign b_arr_c[i] = bus.b_in[i*B_W +: B_W];
  end

  always_comb begin
    term_c.a     = a_arr_c[gnt_id_c];
    term_c.b     = b_arr_c[gnt_id_c];
    term_c.id    = gnt_id_c;
    term_c.first = bus.first[gnt_id_c];
    term_c.last  = bus.last[gnt_id_c];
  end

  // Stage next-state: S1 capture, S2 multiply, S3 accumulate and result formatting.
  always_comb begin
    s1_d      = xfer_c ? term_c : s1_q;
    v1_d      = xfer_c;
    p2_d      = P_W'($signed(s1_q.a)) * P_W'($signed(s1_q.b));
    id2_d     = s1_q.id;
    first2_d  = s1_q.first;
    last2_d   = s1_q.last;
    v2_d      = v1_q;
    acc_sum_c = first2_q ? ACC_W'(p2_q) : acc_q[id2_q] + ACC_W'(p2_q);
    done_valid_d = v2_q & last2_q;
    done_id_d    = done_valid_d ? id2_q : done_id_q;
    done_data_d  = done_valid_d ? sat16(acc_sum_c >>> FRAC) : done_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q         <= '0;
      v1_q         <= 1'b0;
      p2_q         <= '0;
      id2_q        <= '0;
      first2_q     <= 1'b0;
      last2_q      <= 1'b0;
      v2_q         <= 1'b0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      done_data_q  <= '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      s1_q         <= s1_d;
      v1_q         <= v1_d;
      p2_q         <= p2_d;
      id2_q        <= id2_d;
      first2_q     <= first2_d;
      last2_q      <= last2_d;
      v2_q         <= v2_d;
      done_valid_q <= done_valid_d;
      done_id_q    <= done_id_d;
      done_data_q  <= done_data_d;
      if (v2_q) begin
        acc_q[id2_q] <= acc_sum_c;
      end
    end
  end

  assign bus.done_valid = done_valid_q;
  assign bus.done_id    = done_id_q;
  assign bus.done_data  = done_data_q;

endmodule

// File: tb/tb_audio_mac_sched.sv
// Bench for audio_mac_sched: directed scenarios plus random traffic against a queue-based reference.
module tb_audio_mac_sched;
  import audio_mac_pkg::*;

  localparam int NR = int'(N_REQ);

  typedef struct {
    int due;
    int id;
    int data;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  audio_mac_sched_if bus ();

  audio_mac_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     cyc      = 0;
  int     m_ptr    = NR - 1;
  longint m_acc [NR];
  res_t   exp_q [$];
  bit     req_v   [NR];
  int     a_v     [NR];
  int     b_v     [NR];
  bit     first_v [NR];
  bit     last_v  [NR];
  bit     en_v;

  function automatic longint wrap_acc(longint v);
    return (v <<< (64 - ACC_W)) >>> (64 - ACC_W);
  endfunction

  function automatic int sat_ref(longint acc);
    longint s;
    s = acc >>> FRAC;
    if (s > 32767) return 32'h7FFF;
    if (s < -32768) return 32'h8000;
    return int'(s) & 32'hFFFF;
  endfunction

  function automatic int model_gnt();
    if (reset || !en_v) return -1;
    for (int k = 1; k <= NR; k++) begin
      if (req_v[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [N_REQ-1:0] gvec(int g);
    return (g >= 0) ? (N_REQ'(1) << g) : '0;
  endfunction

  task automatic apply();
    for (int i = 0; i < NR; i++) begin
      bus.req[i]               = req_v[i];
      bus.a_in[i*A_W +: A_W]   = A_W'(a_v[i]);
      bus.b_in[i*B_W +: B_W]   = B_W'(b_v[i]);
      bus.first[i]             = first_v[i];
      bus.last[i]              = last_v[i];
    end
    bus.en = en_v;
    #1;
  endtask

  // Advance one edge; the reference consumes the transfer and schedules any result two edges later.
  task automatic tick(output int g);
    longint p;
    g = model_gnt();
    @(posedge clk);
    cyc++;
    if (reset) begin
      m_ptr = NR - 1;
      foreach (m_acc[i]) m_acc[i] = 0;
      exp_q.delete();
    end else if (g >= 0) begin
      m_ptr = g;
      p = longint'(a_v[g]) * longint'(b_v[g]);
      m_acc[g] = wrap_acc(first_v[g] ? p : m_acc[g] + p);
      if (last_v[g]) exp_q.push_back('{cyc + 2, g, sat_ref(m_acc[g])});
    end
    #1;
  endtask

  task automatic clear_reqs();
    foreach (req_v[i]) begin
      req_v[i] = 1'b0; a_v[i] = 0; b_v[i] = 0; first_v[i] = 1'b0; last_v[i] = 1'b0;
    end
  endtask

  task automatic test_reset();
    int g;
    reset = 1'b1;
    en_v  = 1'b1;
    foreach (req_v[i]) begin
      req_v[i] = 1'b1; first_v[i] = 1'b1; last_v[i] = 1'b1;
    end
    apply();
    n_checks++;
    if (bus.gnt !== '0) begin
      n_fail++; $display("FAIL reset_gnt got=%b exp=0", bus.gnt);
    end
    for (int c = 0; c < 2; c++) begin
      tick(g);
      n_checks++;
      if (bus.done_valid !== 1'b0 || bus.done_id !== '0 || bus.done_data !== 16'h0) begin
        n_fail++;
        $display("FAIL reset_out got v=%b id=%0d d=%h exp v=0 id=0 d=0000",
                 bus.done_valid, bus.done_id, bus.done_data);
      end
    end
    reset = 1'b0;
    clear_reqs();
    apply();
  endtask

  task automatic test_single();
    int g; bit ev; int ei; int ed; res_t r;
    for (int c = 0; c < 5; c++) begin
      req_v[0] = (c == 0); first_v[0] = 1'b1; last_v[0] = 1'b1;
      a_v[0] = 32'h4000; b_v[0] = 32'h08000;
      apply();
      n_checks++;
      if (bus.gnt !== gvec(model_gnt()) || (c == 0 && bus.gnt !== 4'b0001)) begin
        n_fail++; $display("FAIL single_gnt c=%0d got=%b exp=%b", c, bus.gnt, gvec(model_gnt()));
      end
      tick(g);
      while (exp_q.size() > 0 && exp_q[0].due < cyc) r = exp_q.pop_front();
      ev = (exp_q.size() > 0 && exp_q[0].due == cyc);
      ei = ev ? exp_q[0].id : 0;
      ed = ev ? exp_q[0].data : 0;
      n_checks++;
      if (bus.done_valid !== ev || (ev && (bus.done_id !== REQ_ID_W'(ei) || bus.done_data !== 16'(ed)))
          || (c == 2 && (bus.done_valid !== 1'b1 || bus.done_id !== '0 || bus.done_data !== 16'h4000))) begin
        n_fail++;
        $display("FAIL single_done c=%0d got v=%b id=%0d d=%h exp v=%b id=%0d d=%h",
                 c, bus.done_valid, bus.done_id, bus.done_data, ev, ei, 16'(ed));
      end
      if (ev) r = exp_q.pop_front();
    end
  endtask

  task automatic test_sequence();
    int g; bit ev; int ei; int ed; res_t r;
    int nd = 0; int did = -1; int dd = -1; int j = 0;
    int seq_a [3] = '{100, 200, -50};
    for (int c = 0; c < 8; c++) begin
      req_v[1] = (j < 3);
      if (j < 3) begin
        a_v[1] = seq_a[j]; b_v[1] = 32'h08000; first_v[1] = (j == 0); last_v[1] = (j == 2);
      end
      apply();
      n_checks++;
      if (bus.gnt !== gvec(model_gnt())) begin
        n_fail++; $display("FAIL seq_gnt c=%0d got=%b exp=%b", c, bus.gnt, gvec(model_gnt()));
      end
      tick(g);
      if (g == 1) j++;
      while (exp_q.size() > 0 && exp_q[0].due < cyc) r = exp_q.pop_front();
      ev = (exp_q.size() > 0 && exp_q[0].due == cyc);
      ei = ev ? exp_q[0].id : 0;
      ed = ev ? exp_q[0].data : 0;
      n_checks++;
      if (bus.done_valid !== ev || (ev && (bus.done_id !== REQ_ID_W'(ei) || bus.done_data !== 16'(ed)))) begin
        n_fail++;
        $display("FAIL seq_done c=%0d got v=%b id=%0d d=%h exp v=%b id=%0d d=%h",
                 c, bus.done_valid, bus.done_id, bus.done_data, ev, ei, 16'(ed));
      end
      if (ev) r = exp_q.pop_front();
      if (bus.done_valid === 1'b1) begin
        nd++; did = int'(bus.done_id); dd = int'(bus.done_data);
      end
    end
    n_checks++;
    if (nd != 1 || did != 1 || dd != 250) begin
      n_fail++; $display("FAIL seq_sum got n=%0d id=%0d d=%0d exp n=1 id=1 d=250", nd, did, dd);
    end
  endtask

  task automatic test_saturation();
    int g; bit ev; int ei; int ed; res_t r;
    int nd = 0; int j = 0;
    int sa [3] = '{32'h7FFF, -32768, -1};
    int sb [3] = '{32'h10000, 32'h10000, 1};
    int sx [3] = '{32'h7FFF, 32'h8000, 32'hFFFF};
    int got [3] = '{-1, -1, -1};
    for (int c = 0; c < 7; c++) begin
      req_v[3] = (j < 3); first_v[3] = 1'b1; last_v[3] = 1'b1;
      if (j < 3) begin
        a_v[3] = sa[j]; b_v[3] = sb[j];
      end
      apply();
      n_checks++;
      if (bus.gnt !== gvec(model_gnt())) begin
        n_fail++; $display("FAIL sat_gnt c=%0d got=%b exp=%b", c, bus.gnt, gvec(model_gnt()));
      end
      tick(g);
      if (g == 3) j++;
      while (exp_q.size() > 0 && exp_q[0].due < cyc) r = exp_q.pop_front();
      ev = (exp_q.size() > 0 && exp_q[0].due == cyc);
      ei = ev ? exp_q[0].id : 0;
      ed = ev ? exp_q[0].data : 0;
      n_checks++;
      if (bus.done_valid !== ev || (ev && (bus.done_id !== REQ_ID_W'(ei) || bus.done_data !== 16'(ed)))) begin
        n_fail++;
        $display("FAIL sat_done c=%0d got v=%b id=%0d d=%h exp v=%b id=%0d d=%h",
                 c, bus.done_valid, bus.done_id, bus.done_data, ev, ei, 16'(ed));
      end
      if (ev) r = exp_q.pop_front();
      if (bus.done_valid === 1'b1 && nd < 3) begin
        got[nd] = int'(bus.done_data); nd++;
      end
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (got[k] != sx[k]) begin
        n_fail++; $display("FAIL sat_value k=%0d got=%h exp=%h", k, got[k], sx[k]);
      end
    end
  endtask

  task automatic test_round_robin();
    int g; bit ev; int ei; int ed; res_t r;
    int nd = 0;
    int ids [8];
    reset = 1'b1;
    clear_reqs();
    apply();
    tick(g);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      foreach (req_v[i]) begin
        req_v[i] = (c < 8); first_v[i] = 1'b1; last_v[i] = 1'b1;
        a_v[i] = 1000 * (i + 1); b_v[i] = 32'h08000;
      end
      apply();
      n_checks++;
      if (bus.gnt !== gvec(model_gnt()) || (c < 8 && bus.gnt !== gvec(c % NR))) begin
        n_fail++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, bus.gnt, gvec(c < 8 ? c % NR : -1));
      end
      tick(g);
      while (exp_q.size() > 0 && exp_q[0].due < cyc) r = exp_q.pop_front();
      ev = (exp_q.size() > 0 && exp_q[0].due == cyc);
      ei = ev ? exp_q[0].id : 0;
      ed = ev ? exp_q[0].data : 0;
      n_checks++;
      if (bus.done_valid !== ev || (ev && (bus.done_id !== REQ_ID_W'(ei) || bus.done_data !== 16'(ed)))
          || (c >= 2 && c < 10 && bus.done_valid !== 1'b1)) begin
        n_fail++;
        $display("FAIL rr_done c=%0d got v=%b id=%0d d=%h exp v=%b id=%0d d=%h",
                 c, bus.done_valid, bus.done_id, bus.done_data, ev, ei, 16'(ed));
      end
      if (ev) r = exp_q.pop_front();
      if (bus.done_valid === 1'b1 && nd < 8) begin
        ids[nd] = int'(bus.done_id); nd++;
      end
    end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (k >= nd || ids[k] != k % NR) begin
        n_fail++; $display("FAIL rr_order k=%0d got=%0d exp=%0d", k, (k < nd) ? ids[k] : -1, k % NR);
      end
    end
  endtask

  task automatic test_en_low();
    int g; bit ev; int ei; int ed; res_t r;
    clear_reqs();
    for (int c = 0; c < 10; c++) begin
      en_v = (c >= 5);
      req_v[0] = (c <= 5); first_v[0] = 1'b1; last_v[0] = 1'b1;
      a_v[0] = -1234; b_v[0] = 32'h08000;
      apply();
      n_checks++;
      if (bus.gnt !== gvec(model_gnt()) || (c < 5 && bus.gnt !== '0) || (c == 5 && bus.gnt !== 4'b0001)) begin
        n_fail++; $display("FAIL en_gnt c=%0d got=%b exp=%b", c, bus.gnt, gvec(model_gnt()));
      end
      tick(g);
      while (exp_q.size() > 0 && exp_q[0].due < cyc) r = exp_q.pop_front();
      ev = (exp_q.size() > 0 && exp_q[0].due == cyc);
      ei = ev ? exp_q[0].id : 0;
      ed = ev ? exp_q[0].data : 0;
      n_checks++;
      if (bus.done_valid !== ev || (ev && (bus.done_id !== REQ_ID_W'(ei) || bus.done_data !== 16'(ed)))
          || (c < 7 && bus.done_valid !== 1'b0)) begin
        n_fail++;
        $display("FAIL en_done c=%0d got v=%b id=%0d d=%h exp v=%b id=%0d d=%h",
                 c, bus.done_valid, bus.done_id, bus.done_data, ev, ei, 16'(ed));
      end
      if (ev) r = exp_q.pop_front();
    end
  endtask

  task automatic test_reset_mid();
    int g; bit ev; int ei; int ed; res_t r;
    int d0 = -1; int d2 = -1;
    clear_reqs();
    en_v = 1'b1;
    for (int c = 0; c < 9; c++) begin
      reset = (c == 2);
      clear_reqs();
      if (c < 2) begin
        req_v[2] = 1'b1; a_v[2] = 300 + 100 * c; b_v[2] = 32'h08000; first_v[2] = (c == 0);
      end else if (c == 3 || c == 4) begin
        req_v[0] = (c == 3); a_v[0] = 500; b_v[0] = 32'h08000; first_v[0] = 1'b1; last_v[0] = 1'b1;
        req_v[2] = 1'b1; a_v[2] = 100; b_v[2] = 32'h08000; last_v[2] = 1'b1;
      end
      apply();
      n_checks++;
      if (bus.gnt !== gvec(model_gnt()) || (c == 3 && bus.gnt !== 4'b0001) || (c == 4 && bus.gnt !== 4'b0100)) begin
        n_fail++; $display("FAIL rst_gnt c=%0d got=%b exp=%b", c, bus.gnt, gvec(model_gnt()));
      end
      tick(g);
      while (exp_q.size() > 0 && exp_q[0].due < cyc) r = exp_q.pop_front();
      ev = (exp_q.size() > 0 && exp_q[0].due == cyc);
      ei = ev ? exp_q[0].id : 0;
      ed = ev ? exp_q[0].data : 0;
      n_checks++;
      if (bus.done_valid !== ev || (ev && (bus.done_id !== REQ_ID_W'(ei) || bus.done_data !== 16'(ed)))
          || (c <= 4 && bus.done_valid !== 1'b0)) begin
        n_fail++;
        $display("FAIL rst_done c=%0d got v=%b id=%0d d=%h exp v=%b id=%0d d=%h",
                 c, bus.done_valid, bus.done_id, bus.done_data, ev, ei, 16'(ed));
      end
      if (ev) r = exp_q.pop_front();
      if (bus.done_valid === 1'b1 && bus.done_id === 2'd0) d0 = int'(bus.done_data);
      if (bus.done_valid === 1'b1 && bus.done_id === 2'd2) d2 = int'(bus.done_data);
    end
    reset = 1'b0;
    n_checks++;
    if (d0 != 500 || d2 != 100) begin
      n_fail++; $display("FAIL rst_fresh_acc got d0=%0d d2=%0d exp d0=500 d2=100", d0, d2);
    end
  endtask

  task automatic test_random();
    int g; bit ev; int ei; int ed; res_t r;
    clear_reqs();
    for (int c = 0; c < 500; c++) begin
      reset = (c < 480) && ($urandom_range(0, 63) == 0);
      en_v  = (c >= 480) || ($urandom_range(0, 7) != 0);
      for (int i = 0; i < NR; i++) begin
        if (c >= 480) begin
          req_v[i] = 1'b0;
        end else if (!req_v[i] && $urandom_range(0, 2) == 0) begin
          req_v[i]   = 1'b1;
          a_v[i]     = int'($signed(A_W'($urandom)));
          b_v[i]     = int'($signed(B_W'($urandom)));
          first_v[i] = ($urandom_range(0, 2) == 0);
          last_v[i]  = ($urandom_range(0, 2) == 0);
        end else if (req_v[i] && $urandom_range(0, 31) == 0) begin
          req_v[i] = 1'b0;
        end
      end
      apply();
      n_checks++;
      if (bus.gnt !== gvec(model_gnt())) begin
        n_fail++; $display("FAIL rand_gnt c=%0d got=%b exp=%b", c, bus.gnt, gvec(model_gnt()));
      end
      tick(g);
      if (g >= 0) req_v[g] = 1'b0;
      while (exp_q.size() > 0 && exp_q[0].due < cyc) r = exp_q.pop_front();
      ev = (exp_q.size() > 0 && exp_q[0].due == cyc);
      ei = ev ? exp_q[0].id : 0;
      ed = ev ? exp_q[0].data : 0;
      n_checks++;
      if (bus.done_valid !== ev || (ev && (bus.done_id !== REQ_ID_W'(ei) || bus.done_data !== 16'(ed)))) begin
        n_fail++;
        $display("FAIL rand_done c=%0d got v=%b id=%0d d=%h exp v=%b id=%0d d=%h",
                 c, bus.done_valid, bus.done_id, bus.done_data, ev, ei, 16'(ed));
      end
      if (ev) r = exp_q.pop_front();
    end
    reset = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL rand_drain got pending=%0d exp pending=0", exp_q.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    en_v  = 1'b0;
    foreach (m_acc[i]) m_acc[i] = 0;
    clear_reqs();
    apply();
    test_reset();
    test_single();
    test_sequence();
    test_saturation();
    test_round_robin();
    test_en_low();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_mac_sched.md
Name: audio_mac_sched

Overview:
Time-shared multiply-accumulate scheduler for the audio conditioning path. Up to N_REQ filter/mixer requesters (e.g. left/right LPF taps, PSG IIR, FM mix gain) share one signed multiplier and a per-requester accumulator bank. A round-robin arbiter admits one operand pair per cycle into a fixed 3-stage pipeline. At the end of each term sequence, a saturated 16-bit result is returned with a requester tag.

Parameters:
N_REQ, 4, number of requesters (2..8)
A_W, 16, signed sample operand width
B_W, 18, signed coefficient operand width
ACC_W, 40, signed accumulator width
FRAC, 15, right-shift applied to accumulator before saturation

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
en  in  1  global issue enable; when low, no new grants
req  in  N_REQ  per-requester request; hold until granted
a_in  in  N_REQ*A_W  packed signed sample operands, requester i at [i*A_W +: A_W]
b_in  in  N_REQ*B_W  packed signed coefficients
first  in  N_REQ  term starts a new sum (accumulator replaced)
last  in  N_REQ  term ends a sum (result emitted)
gnt  out  N_REQ  one-hot grant, combinational from req/en/pointer
done_valid  out  1  single-cycle result strobe
done_id  out  $clog2(N_REQ)  requester index of result
done_data  out  16  saturated signed result

Behaviour:
- Clock is clk. Reset is synchronous and active-high. Reset clears: RR pointer = N_REQ-1, all pipeline valid bits, all accumulators, done_valid/done_id/done_data = 0.
- Arbitration:
  - gnt[i] = en & req[i] & i is the first requester with req set, searching from pointer+1 modulo N_REQ.
  - At most one bit of gnt is set. gnt = 0 when en = 0 or reset = 1.
  - Transfer happens when req[i] & gnt[i] at a clock edge. On transfer, pointer <= i. With no transfer, pointer holds.
  - Requester drops or changes operands only after a transfer edge. Dropping req before grant is legal and issues nothing.
- Pipeline (no stalls once issued; en affects issue only):
  - S1 (transfer edge): register a, b, id, first, last, v1=1.
  - S2: p = signed(a)*signed(b), full A_W+B_W bits; id/flags/valid forwarded.
  - S3:
    - acc[id] <= first ? sext(p) : acc[id] + sext(p), wrapping at ACC_W.
    - If last: done_data <= sat16(acc_next >>> FRAC) (arithmetic shift, truncation toward -inf), done_id <= id, done_valid <= 1; else done_valid <= 0.
- Latency: a term transferred at edge t produces done_valid high during the cycle after edge t+2, i.e. 3 cycles after transfer. Back-to-back terms of the same id accumulate correctly; S3 is the only accumulator writer, and results are in order.
- Throughput: 1 term/cycle aggregate. Max done rate is 1/cycle.
- sat16: value > 32767 gives 0x7FFF; value < -32768 gives 0x8000; otherwise the low 16 bits.
- first & last on the same term: single-term product, emitted.
- Term without first after reset: accumulates onto 0.
- Reset asserted mid-operation: in-flight terms dropped, no done_valid on the following cycle, partial sums lost.
- en deasserted: in-flight terms still complete. Pointer holds.

Decomposition:
- Package audio_mac_pkg:
  - constants REQ_ID_W = $clog2(N_REQ), OUT_W = 16, OUT_MAX = 16'h7FFF, OUT_MIN = 16'h8000.
  - typedef mac_term_t {a, b, id, first, last}.
  - function sat16.
- One sub-module, audio_rr_arb (req, en, pointer update, one-hot gnt). The pipeline and accumulator bank stay in the top.

Test Plan:
- Req0 single term, first=last=1, a=0x4000, b=0x08000 -> gnt=0001 immediately; 3 cycles later done_valid=1, done_id=0, done_data=0x4000.
- Req1 sequence of 3 terms, b=0x08000, a=100, 200, -50 (last on third) -> exactly one done, done_id=1, done_data=250 (0x00FA).
- Saturation: a=0x7FFF, b=0x10000 -> 0x7FFF; a=0x8000, b=0x10000 -> 0x8000; a=-1, b=1 -> 0xFFFF (truncation toward -inf).
- All 4 req held high with en=1 for 8 cycles, first=last=1 -> grants 0,1,2,3,0,1,2,3; done_id in the same order, one per cycle after 3-cycle latency.
- en=0 for 5 cycles with req0 high -> gnt=0 throughout, no done. en=1 -> grant 0 next cycle.
- Reset pulsed 1 cycle after issuing 2 terms from req2 -> no done_valid afterwards; next grant goes to req0; next non-first term from req2 accumulates from 0.
